// File: rtl/mult_share_arbiter.sv
// Shares one 8x8 unsigned multiplier among NREQ requesters through an operand/product pipeline.
// Build option: define MSA_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mult_share_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                res_valid,
    output logic [15:0]         res_product,
    output logic [IDW-1:0]      res_id,
    input  logic                res_ready,
    output logic                busy
);

    logic           v1;
    logic           v2;
    logic [7:0]     a1;
    logic [7:0]     b1;
    logic [IDW-1:0] id1;
    logic [15:0]    p2;
    logic [IDW-1:0] id2;
    logic           load1;
    logic           load2;
    logic           found;
    logic [IDW-1:0] win;
    logic           grant;
    logic [15:0]    prod;

    assign load2 = v1 & (~v2 | res_ready);
    assign load1 = ~v1 | load2;
    assign grant = found & load1 & ~rst;

`ifdef MSA_FIXED_PRIO_EN
    // Lowest set index wins; scanning downward leaves the lowest one in win.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                found = 1'b1;
                win   = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] ptr;

    // Scan from ptr upward with wrap at NREQ; iterating offsets downward
    // lets the smallest offset from ptr be the last (winning) assignment.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[win] = 1'b1;
    end

    // Shift-and-add array multiplier standing in for the shared core.
    always_comb begin
        prod = '0;
        for (int i = 0; i < 8; i++) begin
            if (b1[i]) prod = prod + ({8'b0, a1} << i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            id1 <= '0;
            v2  <= 1'b0;
            p2  <= '0;
            id2 <= '0;
        end else begin
            if (load1) begin
                v1 <= grant;
                if (grant) begin
                    a1  <= req_a[8*win +: 8];
                    b1  <= req_b[8*win +: 8];
                    id1 <= win;
                end
            end
            if (load2) begin
                v2  <= 1'b1;
                p2  <= prod;
                id2 <= id1;
            end else if (res_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    assign res_valid   = v2;
    assign res_product = p2;
    assign res_id      = id2;
    assign busy        = v1 | v2;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (NREQ=4 main instance, NREQ=3 wrap instance).
module tb_mult_share_arbiter;

`ifdef MSA_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [15:0] res_product;
    logic [1:0]  res_id;
    logic        res_ready = 1'b0;
    logic        busy;

    logic [2:0]  req_valid3 = '0;
    logic [23:0] req_a3 = '0;
    logic [23:0] req_b3 = '0;
    logic [2:0]  req_ready3;
    logic        res_valid3;
    logic [15:0] res_product3;
    logic [1:0]  res_id3;
    logic        res_ready3 = 1'b0;
    logic        busy3;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .res_valid(res_valid), .res_product(res_product),
        .res_id(res_id), .res_ready(res_ready), .busy(busy)
    );

    mult_share_arbiter #(.NREQ(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
        .req_ready(req_ready3), .res_valid(res_valid3), .res_product(res_product3),
        .res_id(res_id3), .res_ready(res_ready3), .busy(busy3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                                 input logic rr);
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        res_ready = rr;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        req_valid3 = '0;
        res_ready  = 1'b0;
        res_ready3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] opsA;
        logic [31:0] opsB;
        int          prodTab[4];
        int          accepts;
        int          q[$];
        int          pushed;
        int          popped;
        int          expId;
        int          bCorner[8];
        int          aCorner[4];

        opsA = {8'd200, 8'd11, 8'd7, 8'd3};
        opsB = {8'd2, 8'd13, 8'd9, 8'd5};
        prodTab = '{15, 63, 143, 400};
        bCorner = '{0, 1, 2, 85, 128, 170, 254, 255};
        aCorner = '{0, 1, 128, 255};

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_product", res_product, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single request 255*255
        applyStimulus(4'b0001, 32'd255, 32'd255, 1'b1);
        checkOutput("single_grant", req_ready, 4'b0001);
        applyStimulus(4'b0000, 32'd0, 32'd0, 1'b1);
        checkOutput("single_busy_s1", busy, 1);
        checkOutput("single_noval_s1", res_valid, 0);
        applyStimulus(4'b0000, 32'd0, 32'd0, 1'b1);
        checkOutput("single_valid", res_valid, 1);
        checkOutput("single_product", res_product, 65025);
        checkOutput("single_id", res_id, 0);
        applyStimulus(4'b0000, 32'd0, 32'd0, 1'b1);
        checkOutput("single_drained", res_valid, 0);
        checkOutput("single_busy_low", busy, 0);

        // All four requesters continuously valid
        resetDut();
        for (int c = 0; c < 7; c++) begin
            applyStimulus((c < 5) ? 4'b1111 : 4'b0000, opsA, opsB, 1'b1);
            if (c < 5) checkOutput($sformatf("rr_grant%0d", c), req_ready, FIXED ? 4'b0001 : (4'b0001 << (c % 4)));
            if (c >= 2) begin
                expId = FIXED ? 0 : (c - 2) % 4;
                checkOutput($sformatf("rr_valid%0d", c), res_valid, 1);
                checkOutput($sformatf("rr_prod%0d", c), res_product, prodTab[expId]);
                checkOutput($sformatf("rr_id%0d", c), res_id, expId);
            end
        end

        // Backpressure: res_ready low for 5 cycles
        resetDut();
        accepts = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b1111, opsA, opsB, 1'b0);
            if ((req_valid & req_ready) != 0) accepts++;
            if (c >= 2) begin
                checkOutput($sformatf("bp_ready%0d", c), req_ready, 0);
                checkOutput($sformatf("bp_prod%0d", c), res_product, 15);
                checkOutput($sformatf("bp_id%0d", c), res_id, 0);
            end
        end
        checkOutput("bp_accepts", accepts, 2);
        applyStimulus(4'b0000, opsA, opsB, 1'b1);
        checkOutput("bp_drain1_valid", res_valid, 1);
        checkOutput("bp_drain1_prod", res_product, 15);
        checkOutput("bp_drain1_id", res_id, 0);
        applyStimulus(4'b0000, opsA, opsB, 1'b1);
        checkOutput("bp_drain2_valid", res_valid, 1);
        checkOutput("bp_drain2_prod", res_product, FIXED ? 15 : 63);
        checkOutput("bp_drain2_id", res_id, FIXED ? 0 : 1);
        applyStimulus(4'b0000, opsA, opsB, 1'b1);
        checkOutput("bp_empty", res_valid, 0);
        checkOutput("bp_idle", busy, 0);

        // Operand sweep through requester 0 with a scoreboard
        resetDut();
        pushed = 0;
        popped = 0;
        for (int i = 0; i < 256 * 8 + 256 * 4 + 3; i++) begin
            int a;
            int b;
            logic [3:0] v;
            v = 4'b0001;
            if (i < 256 * 8) begin
                a = i / 8;
                b = bCorner[i % 8];
            end else if (i < 256 * 12) begin
                a = aCorner[(i - 256 * 8) / 256];
                b = (i - 256 * 8) % 256;
            end else begin
                a = 0;
                b = 0;
                v = 4'b0000;
            end
            applyStimulus(v, a, b, 1'b1);
            if (res_valid) begin
                if (q.size() == 0) begin
                    checkOutput("sweep_extra", 1, 0);
                end else begin
                    checkOutput($sformatf("sweep_%0d", popped), res_product, q.pop_front());
                    popped++;
                end
            end
            if (req_ready[0]) begin
                q.push_back(a * b);
                pushed++;
            end
        end
        checkOutput("sweep_pushed", pushed, 256 * 12);
        checkOutput("sweep_left", q.size(), 0);

        // Asynchronous reset with both stages full
        resetDut();
        applyStimulus(4'b1111, opsA, opsB, 1'b0);
        applyStimulus(4'b1111, opsA, opsB, 1'b0);
        applyStimulus(4'b1111, opsA, opsB, 1'b0);
        checkOutput("mid_valid_before", res_valid, 1);
        checkOutput("mid_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_valid_async", res_valid, 0);
        checkOutput("mid_busy_async", busy, 0);
        checkOutput("mid_ready_in_rst", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        res_ready = 1'b1;
        #1;
        checkOutput("mid_ptr_zero", req_ready, 4'b0001);

        // NREQ = 3 wrap behaviour
        resetDut();
        for (int c = 0; c < 6; c++) begin
            logic [2:0] expGrant[4];
            expGrant = '{3'b001, 3'b010, 3'b100, 3'b001};
            @(negedge clk);
            req_valid3 = (c < 4) ? 3'b111 : 3'b000;
            req_a3     = {8'd3, 8'd2, 8'd1};
            req_b3     = {8'd10, 8'd10, 8'd10};
            res_ready3 = 1'b1;
            #1;
            if (c < 4) checkOutput($sformatf("n3_grant%0d", c), req_ready3, FIXED ? 3'b001 : expGrant[c]);
            if (c >= 2) begin
                expId = FIXED ? 0 : (c - 2) % 3;
                checkOutput($sformatf("n3_id%0d", c), res_id3, expId);
                checkOutput($sformatf("n3_prod%0d", c), res_product3, (expId + 1) * 10);
            end
        end
        @(negedge clk);
        #1;
        checkOutput("n3_idle_busy", busy3, 0);
        @(negedge clk);
        req_valid3 = 3'b111;
        #1;
        checkOutput("n3_ptr_held", req_ready3, FIXED ? 3'b001 : 3'b010);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
